// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB widths, page sizes, invtlb op codes, entry types and match helpers
package tlb_pkg;

    localparam int VPPN_W = 19;
    localparam int PPN_W  = 20;
    localparam int PS_W   = 6;
    localparam int ASID_W = 10;
    localparam int PLV_W  = 2;
    localparam int MAT_W  = 2;
    localparam int OP_W   = 5;

    localparam logic [PS_W-1:0] PS_4K = 6'd12;
    localparam logic [PS_W-1:0] PS_2M = 6'd21;

    localparam logic [OP_W-1:0] INV_ALL0       = 5'd0;
    localparam logic [OP_W-1:0] INV_ALL1       = 5'd1;
    localparam logic [OP_W-1:0] INV_G          = 5'd2;
    localparam logic [OP_W-1:0] INV_NG         = 5'd3;
    localparam logic [OP_W-1:0] INV_NG_ASID    = 5'd4;
    localparam logic [OP_W-1:0] INV_NG_ASID_VA = 5'd5;
    localparam logic [OP_W-1:0] INV_GA_VA      = 5'd6;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } inv_state_t;

    typedef struct packed {
        logic [VPPN_W-1:0] vppn;
        logic [PS_W-1:0]   ps;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PPN_W-1:0]  ppn0;
        logic [PPN_W-1:0]  ppn1;
        logic [PLV_W-1:0]  plv0;
        logic [PLV_W-1:0]  plv1;
        logic [MAT_W-1:0]  mat0;
        logic [MAT_W-1:0]  mat1;
        logic              d0;
        logic              d1;
        logic              v0;
        logic              v1;
    } tlb_entry_t;

    typedef struct packed {
        logic              found;
        logic [PPN_W-1:0]  ppn;
        logic [PS_W-1:0]   ps;
        logic [PLV_W-1:0]  plv;
        logic [MAT_W-1:0]  mat;
        logic              d;
        logic              v;
    } tlb_res_t;

    // A 2M page only compares the upper vppn bits; a 4K page compares all of them.
    function automatic logic va_match(input tlb_entry_t ent, input logic [VPPN_W-1:0] vppn);
        return (ent.vppn[18:10] == vppn[18:10]) &&
               ((ent.ps == PS_2M) || (ent.vppn[9:0] == vppn[9:0]));
    endfunction

    function automatic logic entry_hit(input tlb_entry_t ent, input logic [VPPN_W-1:0] vppn,
                                       input logic [ASID_W-1:0] asid);
        return va_match(ent, vppn) && (ent.g || (ent.asid == asid));
    endfunction

    function automatic logic page_odd(input logic [PS_W-1:0] ps, input logic va_bit12,
                                      input logic [VPPN_W-1:0] vppn);
        return ((ps == PS_4K) && va_bit12) || ((ps == PS_2M) && vppn[8]);
    endfunction

endpackage

// File: rtl/tlb_match_enc.sv
// rtl/tlb_match_enc.sv - hit vector to found flag plus lowest matching index
module tlb_match_enc #(
    parameter  int N    = 16,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_match,
    output logic            o_found,
    output logic [IDXW-1:0] o_index
);

    always_comb begin
        o_found = |i_match;
        o_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_index = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_gen2.sv
// rtl/tlb_gen2.sv - two-port searchable TLB with round-robin fill and sequential invtlb sweep
module tlb_gen2
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              s0_req,
    input  logic [VPPN_W-1:0] s0_vppn,
    input  logic              s0_va_bit12,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_resp_valid,
    output logic              s0_found,
    output logic [IDXW-1:0]   s0_index,
    output logic [PPN_W-1:0]  s0_ppn,
    output logic [PS_W-1:0]   s0_ps,
    output logic [PLV_W-1:0]  s0_plv,
    output logic [MAT_W-1:0]  s0_mat,
    output logic              s0_d,
    output logic              s0_v,

    input  logic              s1_req,
    input  logic [VPPN_W-1:0] s1_vppn,
    input  logic              s1_va_bit12,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_resp_valid,
    output logic              s1_found,
    output logic [IDXW-1:0]   s1_index,
    output logic [PPN_W-1:0]  s1_ppn,
    output logic [PS_W-1:0]   s1_ps,
    output logic [PLV_W-1:0]  s1_plv,
    output logic [MAT_W-1:0]  s1_mat,
    output logic              s1_d,
    output logic              s1_v,

    input  logic              we,
    input  logic              w_fill,
    input  logic [IDXW-1:0]   w_index,
    input  logic              w_e,
    input  logic [VPPN_W-1:0] w_vppn,
    input  logic [PS_W-1:0]   w_ps,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [PPN_W-1:0]  w_ppn0,
    input  logic [PPN_W-1:0]  w_ppn1,
    input  logic [PLV_W-1:0]  w_plv0,
    input  logic [PLV_W-1:0]  w_plv1,
    input  logic [MAT_W-1:0]  w_mat0,
    input  logic [MAT_W-1:0]  w_mat1,
    input  logic              w_d0,
    input  logic              w_d1,
    input  logic              w_v0,
    input  logic              w_v1,

    input  logic [IDXW-1:0]   r_index,
    output logic              r_e,
    output logic [VPPN_W-1:0] r_vppn,
    output logic [PS_W-1:0]   r_ps,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [PPN_W-1:0]  r_ppn0,
    output logic [PPN_W-1:0]  r_ppn1,
    output logic [PLV_W-1:0]  r_plv0,
    output logic [PLV_W-1:0]  r_plv1,
    output logic [MAT_W-1:0]  r_mat0,
    output logic [MAT_W-1:0]  r_mat1,
    output logic              r_d0,
    output logic              r_d1,
    output logic              r_v0,
    output logic              r_v1,

    input  logic              invtlb_valid,
    input  logic [OP_W-1:0]   invtlb_op,
    input  logic [ASID_W-1:0] invtlb_asid,
    input  logic [VPPN_W-1:0] invtlb_vppn,
    output logic              invtlb_busy,
    output logic              invtlb_done,
    output logic              invtlb_badop,

    output logic [IDXW-1:0]   fill_index
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    tlb_entry_t        r_ent [TLBNUM];
    logic [TLBNUM-1:0] r_ent_e;
    logic [IDXW-1:0]   r_fill;
    inv_state_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_badop;
    logic [IDXW-1:0]   r_sw_cnt;
    logic [OP_W-1:0]   r_op;
    logic [ASID_W-1:0] r_inv_asid;
    logic [VPPN_W-1:0] r_inv_vppn;

    logic              w_wr_acc;
    logic [IDXW-1:0]   w_wr_idx;
    tlb_entry_t        w_wr_ent;

    assign w_wr_acc = we && !r_busy;
    assign w_wr_idx = w_fill ? r_fill : w_index;

    always_comb begin
        w_wr_ent.vppn = w_vppn;
        w_wr_ent.ps   = w_ps;
        w_wr_ent.asid = w_asid;
        w_wr_ent.g    = w_g;
        w_wr_ent.ppn0 = w_ppn0;
        w_wr_ent.ppn1 = w_ppn1;
        w_wr_ent.plv0 = w_plv0;
        w_wr_ent.plv1 = w_plv1;
        w_wr_ent.mat0 = w_mat0;
        w_wr_ent.mat1 = w_mat1;
        w_wr_ent.d0   = w_d0;
        w_wr_ent.d1   = w_d1;
        w_wr_ent.v0   = w_v0;
        w_wr_ent.v1   = w_v1;
    end

    // Payload fields carry no reset; only the E bits decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_ent[w_wr_idx] <= w_wr_ent;
        end
    end

    logic              w_req      [2];
    logic [VPPN_W-1:0] w_key_vppn [2];
    logic              w_key_b12  [2];
    logic [ASID_W-1:0] w_key_asid [2];

    assign w_req[0]      = s0_req;
    assign w_req[1]      = s1_req;
    assign w_key_vppn[0] = s0_vppn;
    assign w_key_vppn[1] = s1_vppn;
    assign w_key_b12[0]  = s0_va_bit12;
    assign w_key_b12[1]  = s1_va_bit12;
    assign w_key_asid[0] = s0_asid;
    assign w_key_asid[1] = s1_asid;

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        logic [TLBNUM-1:0] w_match;
        logic              w_found;
        logic [IDXW-1:0]   w_idx;
        tlb_entry_t        w_sel;
        logic              w_odd;
        tlb_res_t          w_res;
        tlb_res_t          r_res;
        logic [IDXW-1:0]   r_idx;
        logic              r_vld;

        always_comb begin
            for (int i = 0; i < TLBNUM; i++) begin
                w_match[i] = r_ent_e[i] && entry_hit(r_ent[i], w_key_vppn[gp], w_key_asid[gp]);
            end
        end

        tlb_match_enc #(.N(TLBNUM)) u_enc (
            .i_match (w_match),
            .o_found (w_found),
            .o_index (w_idx)
        );

        assign w_sel = r_ent[w_idx];
        assign w_odd = page_odd(w_sel.ps, w_key_b12[gp], w_key_vppn[gp]);

        always_comb begin
            w_res = '0;
            if (w_found) begin
                w_res.found = 1'b1;
                w_res.ppn   = w_odd ? w_sel.ppn1 : w_sel.ppn0;
                w_res.ps    = w_sel.ps;
                w_res.plv   = w_odd ? w_sel.plv1 : w_sel.plv0;
                w_res.mat   = w_odd ? w_sel.mat1 : w_sel.mat0;
                w_res.d     = w_odd ? w_sel.d1 : w_sel.d0;
                w_res.v     = w_odd ? w_sel.v1 : w_sel.v0;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_vld <= 1'b0;
                r_res <= '0;
                r_idx <= '0;
            end else begin
                r_vld <= w_req[gp];
                if (w_req[gp]) begin
                    r_res <= w_res;
                    r_idx <= w_idx;
                end
            end
        end
    end

    assign s0_resp_valid = g_port[0].r_vld;
    assign s0_found      = g_port[0].r_res.found;
    assign s0_index      = g_port[0].r_idx;
    assign s0_ppn        = g_port[0].r_res.ppn;
    assign s0_ps         = g_port[0].r_res.ps;
    assign s0_plv        = g_port[0].r_res.plv;
    assign s0_mat        = g_port[0].r_res.mat;
    assign s0_d          = g_port[0].r_res.d;
    assign s0_v          = g_port[0].r_res.v;

    assign s1_resp_valid = g_port[1].r_vld;
    assign s1_found      = g_port[1].r_res.found;
    assign s1_index      = g_port[1].r_idx;
    assign s1_ppn        = g_port[1].r_res.ppn;
    assign s1_ps         = g_port[1].r_res.ps;
    assign s1_plv        = g_port[1].r_res.plv;
    assign s1_mat        = g_port[1].r_res.mat;
    assign s1_d          = g_port[1].r_res.d;
    assign s1_v          = g_port[1].r_res.v;

    tlb_entry_t w_sw_ent;
    logic       w_sw_asid_eq;
    logic       w_sw_va_eq;
    logic       w_sw_clr;

    assign w_sw_ent     = r_ent[r_sw_cnt];
    assign w_sw_asid_eq = (w_sw_ent.asid == r_inv_asid);
    assign w_sw_va_eq   = va_match(w_sw_ent, r_inv_vppn);

    always_comb begin
        w_sw_clr = 1'b0;
        case (r_op)
            INV_ALL0, INV_ALL1: w_sw_clr = 1'b1;
            INV_G:              w_sw_clr = w_sw_ent.g;
            INV_NG:             w_sw_clr = !w_sw_ent.g;
            INV_NG_ASID:        w_sw_clr = !w_sw_ent.g && w_sw_asid_eq;
            INV_NG_ASID_VA:     w_sw_clr = !w_sw_ent.g && w_sw_asid_eq && w_sw_va_eq;
            INV_GA_VA:          w_sw_clr = (w_sw_ent.g || w_sw_asid_eq) && w_sw_va_eq;
            default:            w_sw_clr = 1'b0;
        endcase
    end

    // Writes are only accepted outside SWEEP, so they never collide with a sweep clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ent_e    <= '0;
            r_fill     <= '0;
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_badop    <= 1'b0;
            r_sw_cnt   <= '0;
            r_op       <= '0;
            r_inv_asid <= '0;
            r_inv_vppn <= '0;
        end else begin
            r_done  <= 1'b0;
            r_badop <= 1'b0;
            if (w_wr_acc) begin
                r_ent_e[w_wr_idx] <= w_e;
                if (w_fill) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (invtlb_valid) begin
                        if (invtlb_op <= INV_GA_VA) begin
                            r_op       <= invtlb_op;
                            r_inv_asid <= invtlb_asid;
                            r_inv_vppn <= invtlb_vppn;
                            r_sw_cnt   <= '0;
                            r_state    <= ST_SWEEP;
                            r_busy     <= 1'b1;
                        end else begin
                            r_badop <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    if (w_sw_clr) begin
                        r_ent_e[r_sw_cnt] <= 1'b0;
                    end
                    if (r_sw_cnt == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_sw_cnt <= r_sw_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign invtlb_busy  = r_busy;
    assign invtlb_done  = r_done;
    assign invtlb_badop = r_badop;
    assign fill_index   = r_fill;

    assign r_e    = r_ent_e[r_index];
    assign r_vppn = r_ent[r_index].vppn;
    assign r_ps   = r_ent[r_index].ps;
    assign r_asid = r_ent[r_index].asid;
    assign r_g    = r_ent[r_index].g;
    assign r_ppn0 = r_ent[r_index].ppn0;
    assign r_ppn1 = r_ent[r_index].ppn1;
    assign r_plv0 = r_ent[r_index].plv0;
    assign r_plv1 = r_ent[r_index].plv1;
    assign r_mat0 = r_ent[r_index].mat0;
    assign r_mat1 = r_ent[r_index].mat1;
    assign r_d0   = r_ent[r_index].d0;
    assign r_d1   = r_ent[r_index].d1;
    assign r_v0   = r_ent[r_index].v0;
    assign r_v1   = r_ent[r_index].v1;

endmodule

// File: doc/tlb_gen2.md
TLB_GEN2 -- requirements
Module: tlb_gen2

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning entry count (power of two, 4..64); IDXW = log2(TLBNUM).
REQ-002 SHALL have port clk  in  1  the single clock.
REQ-003 SHALL have port resetn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port s0_req  in  1  search request on port 0.
REQ-005 SHALL have ports s0_vppn  in  19, s0_va_bit12  in  1, s0_asid  in  10  search key.
REQ-006 SHALL have port s0_resp_valid  out  1  search result valid.
REQ-007 SHALL have result ports, all out: s0_found 1, s0_index IDXW, s0_ppn 20, s0_ps 6, s0_plv 2, s0_mat 2, s0_d 1, s0_v 1.
REQ-008 SHALL have an identical port set with prefix s1_ for search port 1.
REQ-009 SHALL have write ports, all in: we 1, w_fill 1 (use fill_index, ignore w_index), w_index IDXW, and fields w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0/1, w_plv0/1, w_mat0/1, w_d0/1, w_v0/1.
REQ-010 SHALL have read ports: r_index in IDXW, plus outputs r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1.
REQ-011 SHALL have inputs invtlb_valid 1, invtlb_op 5, invtlb_asid 10, invtlb_vppn 19; outputs invtlb_busy 1, invtlb_done 1, invtlb_badop 1.
REQ-012 SHALL have port fill_index  out  IDXW  round-robin replacement pointer.

Function
REQ-013 SHALL match entry i when: E; vppn[18:10] equal; (asid equal or G); and (ps==21 or vppn[9:0] equal).
REQ-014 SHALL register search results: s*_req at edge N gives results and s*_resp_valid=1 at edge N+1. s*_resp_valid=0 the cycle after no request.
REQ-015 SHALL report the lowest matching index on multiple hits. On no hit: found=0 and all other result fields 0.
REQ-016 SHALL select odd page when (ps==12 and va_bit12) or (ps==21 and vppn[8]), else even page.
REQ-017 SHALL make reads combinational from r_index.
REQ-018 SHALL write entry on the edge with we=1, at fill_index if w_fill else w_index.
REQ-019 SHALL give a same-cycle search the pre-write contents.
REQ-020 SHALL advance fill_index by 1 (mod TLBNUM, wrapping TLBNUM-1 to 0) on each accepted write with w_fill=1.
REQ-021 SHALL run invtlb FSM states IDLE and SWEEP. In IDLE, invtlb_valid with op 0..6 latches op/asid/vppn, sets sweep counter 0, enters SWEEP, invtlb_busy=1.
REQ-022 SHALL in SWEEP evaluate one entry per cycle and clear its E when the op holds:
  - 0 or 1: all entries
  - 2: G=1
  - 3: G=0
  - 4: G=0 and asid equal
  - 5: G=0, asid equal, and VA match per REQ-013
  - 6: (G=1 or asid equal) and VA match
REQ-023 SHALL return to IDLE after entry TLBNUM-1 (sweep = TLBNUM cycles) and pulse invtlb_done for 1 cycle on that edge.
REQ-024 SHALL on invtlb_valid with op>6 in IDLE leave the TLB unchanged, pulse invtlb_badop for 1 cycle next edge, stay IDLE.
REQ-025 SHALL ignore we and invtlb_valid while invtlb_busy=1 (fill_index holds). Searches proceed against current contents.

Reset
REQ-026 SHALL on resetn=0 at an edge, including mid-SWEEP: clear all E bits, fill_index=0, FSM=IDLE, and all s*_ result outputs, s*_resp_valid, invtlb_busy, invtlb_done, invtlb_badop = 0. Non-E fields are unreset.

Structure
REQ-027 SHALL place invtlb op codes (0..6), page-size constants 12 and 21, and entry field widths in shared package tlb_pkg.
REQ-028 SHALL instantiate match/priority logic as sub-module tlb_match_enc (TLBNUM match vector to found + lowest index), once per search port.

Verification
REQ-029 SHALL cover: write idx 3 (E=1, vppn=0x12345, ps=12, asid=5, G=0, ppn1=0xABCDE), s0 search vppn 0x12345, bit12=1, asid 5 -> cycle+1 found=1, index=3, ppn=0xABCDE.
REQ-030 SHALL cover: entries 2 and 7 both matching ps=21 with vppn[8]=1 -> index=2, odd-page fields of entry 2.
REQ-031 SHALL cover: TLBNUM+1 fill writes from reset -> fill_index sequence 0..TLBNUM-1, then 0; last write lands in entry 0.
REQ-032 SHALL cover: entries G=1 at 1, G=0 asid 9 at 4, G=0 asid 8 at 6, then invtlb op 4 asid 9 -> busy TLBNUM cycles, done pulse; only entry 4 E=0. A we during busy -> no write.
REQ-033 SHALL cover: invtlb op 9 -> badop pulse 1 cycle, busy stays 0, contents unchanged. resetn=0 at sweep cycle 5 -> all E=0, busy=0 next cycle.
